// File: rtl/s_term_frame_strobe_pkg.sv
// rtl/s_term_frame_strobe_pkg.sv - shared types, widths and one-hot helper for the column strobe generator
package s_term_frame_strobe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam int COL_ADDR_W   = 5;
    localparam int FRAME_ADDR_W = 5;

    // Index width accepted by the helper; callers cast their frame field to it.
    localparam int FRAME_IDX_W  = 8;

    // Widest strobe bus the helper can build; six index bits address it.
    localparam int MAX_STROBE_W = 64;

    // Strobe hold counter width; holds StrobeCycles-1 for StrobeCycles up to 15.
    localparam int STROBE_CNT_W = 4;

    // One-hot vector with bit idx set; all zero when idx is outside 0..n-1.
    function automatic logic [MAX_STROBE_W-1:0] frame_onehot(
        input logic [FRAME_IDX_W-1:0] idx,
        input int                     n
    );
        logic [MAX_STROBE_W-1:0] v;
        v = '0;
        if ((int'({1'b0, idx}) < n) && (n <= MAX_STROBE_W)) begin
            v[idx[5:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/s_term_frame_strobe_decoder.sv
// rtl/s_term_frame_strobe_decoder.sv - registered index-to-one-hot decoder driving the column FrameStrobe bus
module s_term_frame_strobe_decoder
    import s_term_frame_strobe_pkg::*;
#(
    parameter int Width    = 20,
    parameter int IdxWidth = 5
) (
    input  logic                clk_i,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [IdxWidth-1:0] idx_i,
    output logic [Width-1:0]    strobe_o
);

    logic [Width-1:0] strobe_q;
    logic [Width-1:0] strobe_d;

    // Decode the index only while enabled; otherwise the bus rests at zero.
    always_comb begin
        strobe_d = '0;
        if (en_i) begin
            strobe_d = Width'(frame_onehot(FRAME_IDX_W'(idx_i), Width));
        end
    end

    // Output register keeps the strobe free of any combinational path from inputs.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/s_term_frame_strobe.sv
// rtl/s_term_frame_strobe.sv - per-column frame-strobe generator with setup/hold guard cycles
module s_term_frame_strobe
    import s_term_frame_strobe_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int ColIndex        = 0,
    parameter int ColAddrWidth    = COL_ADDR_W,
    parameter int FrameAddrWidth  = FRAME_ADDR_W,
    parameter int StrobeCycles    = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CmdValid,
    output logic                       CmdReady,
    input  logic [ColAddrWidth-1:0]    CmdColumn,
    input  logic [FrameAddrWidth-1:0]  CmdFrame,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       Busy,
    output logic                       ErrFrame,
    output logic [15:0]                FrameCount
);

    localparam logic [ColAddrWidth-1:0]   COL_SELF    = ColAddrWidth'(ColIndex);
    localparam logic [FrameAddrWidth:0]   FRAME_LIMIT = (FrameAddrWidth + 1)'(MaxFramesPerCol);
    localparam logic [STROBE_CNT_W-1:0]   STROBE_LOAD = STROBE_CNT_W'(StrobeCycles - 1);

    // Reject parameter sets the strobe bus, counter or frame field cannot represent.
    if ((StrobeCycles < 1) || (StrobeCycles > 15) || (MaxFramesPerCol < 1) ||
        (MaxFramesPerCol > MAX_STROBE_W) || ((1 << FrameAddrWidth) < MaxFramesPerCol) ||
        (FrameBitsPerRow < 1)) begin : g_param_check
        $error("s_term_frame_strobe: illegal parameter combination");
    end

    state_t                      state_q, state_d;
    logic [STROBE_CNT_W-1:0]     cnt_q, cnt_d;
    logic [FrameAddrWidth-1:0]   frame_q, frame_d;
    logic                        err_q, err_d;
    logic [15:0]                 count_q, count_d;
    logic                        accept;
    logic                        col_hit;
    logic                        frame_oor;
    logic                        strobe_en;

    assign accept    = CmdValid && (state_q == ST_IDLE);
    assign col_hit   = (CmdColumn == COL_SELF);
    assign frame_oor = ({1'b0, CmdFrame} >= FRAME_LIMIT);

    // Strobe register is loaded for the cycle after ARM and for every STROBE cycle but the last.
    assign strobe_en = (state_q == ST_ARM) || ((state_q == ST_STROBE) && (cnt_q != '0));

    // Next-state logic: command intake, guard cycles, hold counter, error flag and frame count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && col_hit) begin
                    if (frame_oor) begin
                        err_d = 1'b1;
                    end else begin
                        frame_d = CmdFrame;
                        state_d = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                cnt_d   = STROBE_LOAD;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                count_d = count_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset wins over any command presented on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    s_term_frame_strobe_decoder #(
        .Width    (MaxFramesPerCol),
        .IdxWidth (FrameAddrWidth)
    ) u_decoder (
        .clk_i    (CLK),
        .clr_i    (RST),
        .en_i     (strobe_en),
        .idx_i    (frame_q),
        .strobe_o (FrameStrobe)
    );

    assign CmdReady   = (state_q == ST_IDLE);
    assign Busy       = (state_q != ST_IDLE);
    assign ErrFrame   = err_q;
    assign FrameCount = count_q;

endmodule
